// File: rtl/neuron_weight_ram_pkg.sv
// Shared types and default widths for the neuron weight/activation memory.
package neuron_weight_ram_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/neuron_ram_core.sv
// Plain dual-port word array: synchronous write, read address resolved with
// write-first bypass so a same-cycle write is visible to the reader.
module neuron_ram_core
  import neuron_weight_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_word
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_word = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];

endmodule

// File: rtl/neuron_weight_ram.sv
// Weight memory with a burst read sequencer: streams rd_len words from rd_base,
// one per cycle, flagged with rd_valid/rd_last and followed by a done pulse.
module neuron_weight_ram
  import neuron_weight_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic              rd_abort,
  output logic              busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done
);

  seq_state_t        state_p0, state_nxt;
  logic [ADDR_W-1:0] addr_p0, addr_nxt;
  logic [LEN_W-1:0]  rem_p0, rem_nxt;
  logic              issue_p0, issue_last_p0, done_nxt;
  logic [DATA_W-1:0] ram_word;

  logic              vld_p1, last_p1, done_p1;
  logic [DATA_W-1:0] data_p1;

  neuron_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .wr_en   (wr_en & ~rst),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (addr_p0),
    .rd_word (ram_word)
  );

  always_comb begin
    state_nxt     = state_p0;
    addr_nxt      = addr_p0;
    rem_nxt       = rem_p0;
    issue_p0      = 1'b0;
    issue_last_p0 = 1'b0;
    done_nxt      = 1'b0;
    case (state_p0)
      ST_IDLE: begin
        if (rd_start) begin
          if (rd_len != '0) begin
            addr_nxt  = rd_base;
            rem_nxt   = rd_len;
            state_nxt = ST_RUN;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (rd_abort) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          issue_p0 = 1'b1;
          addr_nxt = addr_p0 + ADDR_W'(1);
          rem_nxt  = rem_p0 - LEN_W'(1);
          if (rem_p0 == LEN_W'(1)) begin
            issue_last_p0 = 1'b1;
            state_nxt     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // p0 -> p1: sequencer state advances, issued word registered onto the output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= ST_IDLE;
      addr_p0  <= '0;
      rem_p0   <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      done_p1  <= 1'b0;
      data_p1  <= '0;
    end else begin
      state_p0 <= state_nxt;
      addr_p0  <= addr_nxt;
      rem_p0   <= rem_nxt;
      vld_p1   <= issue_p0;
      last_p1  <= issue_last_p0;
      done_p1  <= done_nxt;
      if (issue_p0) data_p1 <= ram_word;
    end
  end

  assign busy     = (state_p0 != ST_IDLE);
  assign rd_valid = vld_p1;
  assign rd_last  = last_p1;
  assign rd_data  = data_p1;
  assign done     = done_p1;

endmodule

// File: tb/tb_neuron_weight_ram.sv
// Self-checking bench for neuron_weight_ram against a word-array reference model.
module tb_neuron_weight_ram;

  localparam int DEPTH = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_start;
  logic [6:0] rd_base;
  logic [7:0] rd_len;
  logic       rd_abort;
  logic       busy, rd_valid, rd_last, done;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] ref_mem [DEPTH];
  int rb, rl, rc;

  neuron_weight_ram dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_start (rd_start),
    .rd_base  (rd_base),
    .rd_len   (rd_len),
    .rd_abort (rd_abort),
    .busy     (busy),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic write_word(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a[6:0];
    wr_data = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset.busy got %b exp 0", busy); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset.rd_valid got %b exp 0", rd_valid); end
    n_checks++; if (rd_last !== 1'b0)  begin n_fail++; $display("FAIL reset.rd_last got %b exp 0", rd_last); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset.done got %b exp 0", done); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset.rd_data got %h exp 00", rd_data); end
    rst = 1'b0;
  endtask

  // Streams one burst; expected word for each slot is the reference memory
  // contents at issue time, after that cycle's write (write-first).
  task automatic test_stream(input int base, input int len, input int coll_idx,
                             input bit rand_wr, input bit rand_start, input string name);
    logic [7:0] exp_q [$];
    logic [7:0] e;
    int a;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s.idle_busy got %b exp 0", name, busy); end
    rd_start = 1'b1;
    rd_base  = base[6:0];
    rd_len   = len[7:0];
    for (int t = 1; t <= len + 2; t++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== (t <= len + 1)) begin n_fail++; $display("FAIL %s.busy t=%0d got %b exp %b", name, t, busy, (t <= len + 1)); end
      n_checks++;
      if (rd_valid !== (t >= 2 && t <= len + 1)) begin
        n_fail++; $display("FAIL %s.rd_valid t=%0d got %b exp %b", name, t, rd_valid, (t >= 2 && t <= len + 1));
      end
      if (t >= 2 && t <= len + 1) begin
        e = exp_q.pop_front();
        n_checks++; if (rd_data !== e) begin n_fail++; $display("FAIL %s.rd_data t=%0d got %h exp %h", name, t, rd_data, e); end
        n_checks++; if (rd_last !== (t == len + 1)) begin n_fail++; $display("FAIL %s.rd_last t=%0d got %b exp %b", name, t, rd_last, (t == len + 1)); end
      end
      n_checks++;
      if (done !== (t == len + 2)) begin n_fail++; $display("FAIL %s.done t=%0d got %b exp %b", name, t, done, (t == len + 2)); end
      rd_start = 1'b0;
      wr_en    = 1'b0;
      if (rand_start && t <= len + 1) begin
        rd_start = 1'($urandom_range(0, 1));
        rd_base  = 7'($urandom_range(0, DEPTH - 1));
        rd_len   = 8'($urandom_range(0, 255));
      end
      if (t <= len) begin
        a = (base + t - 1) % DEPTH;
        if (t - 1 == coll_idx) begin
          wr_en = 1'b1; wr_addr = a[6:0]; wr_data = 8'hAA;
        end else if (rand_wr && $urandom_range(0, 1) == 1) begin
          wr_en = 1'b1; wr_addr = 7'($urandom_range(0, DEPTH - 1)); wr_data = 8'($urandom_range(0, 255));
        end
        if (wr_en) ref_mem[wr_addr] = wr_data;
        exp_q.push_back(ref_mem[a]);
      end
    end
    wr_en    = 1'b0;
    rd_start = 1'b0;
  endtask

  task automatic test_abort();
    @(negedge clk);
    rd_start = 1'b1; rd_base = 7'd0; rd_len = 8'd10;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      rd_start = 1'b0;
    end
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL abort.third_valid got %b exp 1", rd_valid); end
    n_checks++; if (rd_data !== ref_mem[2]) begin n_fail++; $display("FAIL abort.third_data got %h exp %h", rd_data, ref_mem[2]); end
    rd_abort = 1'b1;
    @(negedge clk);
    rd_abort = 1'b0;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL abort.rd_valid got %b exp 0", rd_valid); end
    n_checks++; if (rd_last !== 1'b0)  begin n_fail++; $display("FAIL abort.rd_last got %b exp 0", rd_last); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL abort.busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b1)     begin n_fail++; $display("FAIL abort.done got %b exp 1", done); end
    n_checks++; if (rd_data !== ref_mem[2]) begin n_fail++; $display("FAIL abort.hold got %h exp %h", rd_data, ref_mem[2]); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort.done_once got %b exp 0", done); end
    rd_abort = 1'b1;
    @(negedge clk);
    rd_abort = 1'b0;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort.idle_done got %b exp 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort.idle_busy got %b exp 0", busy); end
    // abort on the cycle the final word is issued must suppress it
    rd_start = 1'b1; rd_base = 7'd40; rd_len = 8'd2;
    @(negedge clk);
    rd_start = 1'b0;
    @(negedge clk);
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== ref_mem[40]) begin
      n_fail++; $display("FAIL abort.prio_first got v=%b d=%h exp v=1 d=%h", rd_valid, rd_data, ref_mem[40]);
    end
    rd_abort = 1'b1;
    @(negedge clk);
    rd_abort = 1'b0;
    n_checks++; if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin
      n_fail++; $display("FAIL abort.prio_valid got v=%b l=%b exp v=0 l=0", rd_valid, rd_last);
    end
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort.prio_done got done=%b busy=%b exp done=1 busy=0", done, busy);
    end
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    rd_start = 1'b1; rd_base = 7'd17; rd_len = 8'd0;
    @(negedge clk);
    rd_start = 1'b0;
    n_checks++; if (done !== 1'b1)     begin n_fail++; $display("FAIL zero.done got %b exp 1", done); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL zero.rd_valid got %b exp 0", rd_valid); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL zero.busy got %b exp 0", busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero.after got done=%b v=%b exp 0 0", done, rd_valid);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rd_start = 1'b1; rd_base = 7'd60; rd_len = 8'd8;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      rd_start = 1'b0;
    end
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL areset.pre_valid got %b exp 1", rd_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL areset.rd_valid got %b exp 0", rd_valid); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL areset.busy got %b exp 0", busy); end
    n_checks++; if (rd_last !== 1'b0)  begin n_fail++; $display("FAIL areset.rd_last got %b exp 0", rd_last); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL areset.done got %b exp 0", done); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL areset.rd_data got %h exp 00", rd_data); end
    // a write attempted while reset is held must not land
    wr_en = 1'b1; wr_addr = 7'd62; wr_data = ~ref_mem[62];
    @(posedge clk);
    #1 wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL areset.release got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0; rd_abort = 1'b0;
    test_reset();
    for (int i = 0; i < DEPTH; i++) write_word(i, 8'($urandom_range(0, 255)));
    write_word(0, 8'd10); write_word(1, 8'd10); write_word(2, 8'd11); write_word(3, 8'd11);
    test_stream(0, 4, -1, 1'b0, 1'b0, "basic");
    write_word(126, 8'd5); write_word(127, 8'd6); write_word(0, 8'd7);
    test_stream(126, 3, -1, 1'b0, 1'b0, "wrap");
    test_stream(20, 12, 5, 1'b1, 1'b0, "collide");
    test_abort();
    test_stream(7, 5, -1, 1'b0, 1'b0, "after_abort");
    test_zero_len();
    test_stream(30, 9, -1, 1'b0, 1'b1, "ignore_start");
    repeat (6) begin
      rb = $urandom_range(0, DEPTH - 1);
      rl = $urandom_range(1, 40);
      rc = ($urandom_range(0, 1) == 1) ? $urandom_range(0, rl - 1) : -1;
      test_stream(rb, rl, rc, 1'b1, 1'b1, "random");
    end
    test_stream(100, 200, -1, 1'b1, 1'b0, "long");
    test_async_reset();
    test_stream(60, 8, -1, 1'b0, 1'b0, "post_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_weight_ram.md
Name: neuron_weight_ram

Overview:
Parametrised dual-port weight/activation memory for neuron datapaths: one synchronous write port plus one streaming read port driven by an internal burst sequencer. The multiply-accumulate stage requests a burst of N consecutive words from a base address; the block emits them one per cycle with valid/last flags. It replaces the fixed 8-bit, tristate-output neuron RAM with a registered, collision-defined, reset-safe memory.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 7, address width; DEPTH = 2**ADDR_W words
LEN_W, 8, width of burst length field

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_start  in  1  start burst (sampled only in IDLE)
rd_base  in  ADDR_W  burst start address
rd_len  in  LEN_W  number of words in burst
rd_abort  in  1  terminate burst
busy  out  1  sequencer in RUN or DRAIN
rd_valid  out  1  rd_data holds a burst word
rd_data  out  DATA_W  read word
rd_last  out  1  final word of burst (qualified by rd_valid)
done  out  1  one-cycle pulse after last word or abort

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, busy=0, rd_valid=0, rd_data=0, rd_last=0, done=0, counters 0. Memory contents NOT reset; optional init via simulation only.
- Write: if wr_en, mem[wr_addr] <= wr_data on clk edge; independent of sequencer state; active during reset deassertion only (writes ignored while rst=1).
- States: IDLE, RUN, DRAIN.
- IDLE: rd_start=1 and rd_len!=0 -> latch addr=rd_base, remaining=rd_len, go RUN. rd_len=0 -> stay IDLE, pulse done next cycle, no rd_valid. rd_start ignored outside IDLE.
- RUN: each cycle issue read at addr; addr <= addr+1 mod DEPTH (wrap DEPTH-1 -> 0); remaining decrements; on issuing final word (remaining==1) go DRAIN.
- Read latency 1: word issued in cycle t appears on rd_data with rd_valid=1 in cycle t+1. Burst of N gives N consecutive rd_valid cycles, no bubbles; rd_last=1 on the Nth.
- DRAIN: outputs final word (rd_valid=1, rd_last=1), then IDLE; done pulses the cycle after rd_last (busy=0 in that cycle).
- Collision: read and write same address same cycle -> read returns NEW wr_data (write-first bypass). Different addresses independent.
- rd_abort in RUN or DRAIN: next cycle rd_valid=0, rd_last=0, state IDLE, done=1 for one cycle; in-flight word discarded. rd_abort in IDLE ignored. rd_abort has priority over completion in same cycle.
- rd_data holds last value when rd_valid=0 (not forced to 0, no Z).
- rd_len > DEPTH permitted: addresses wrap and repeat.
- Async reset mid-burst: immediate return to reset values; no done pulse.

Decomposition:
- Shared package/header: state encodings (IDLE/RUN/DRAIN), default DATA_W/ADDR_W/LEN_W constants.
- One sub-module natural: neuron_ram_core (plain synchronous dual-port array with write-first bypass, no reset); top holds sequencer FSM and output registers.

Test Plan:
- Reset then write mem[0..3]=10,10,11,11; burst base=0 len=4 -> rd_valid cycles 2..5 after start, data 10,10,11,11, rd_last on 11 (4th), done one cycle later.
- Wrap: DEPTH=128, write mem[126]=5,mem[127]=6,mem[0]=7; burst base=126 len=3 -> 5,6,7, rd_last on 7.
- Collision: during burst, write addr being read that cycle with 0xAA -> that output word = 0xAA; writes to other addresses do not disturb stream.
- Abort: burst base=0 len=10, assert rd_abort on 3rd rd_valid -> rd_valid=0 next cycle, done=1 one cycle, busy=0; subsequent rd_start accepted.
- Zero length and ignored start: rd_len=0 -> no rd_valid, done pulse; rd_start during RUN -> ignored, original burst completes unchanged.
- Async reset asserted mid-burst (between clk edges) -> rd_valid, busy, rd_last, done drop to 0 immediately; memory data preserved (re-burst returns prior values).
